// File: rtl/reglk_pkg.sv
// Shared types, word-map offsets and the byte-enable merge helper for the register-lock bank.
package reglk_pkg;

    typedef enum logic [1:0] {
        OPEN     = 2'd0,
        LOCKED   = 2'd1,
        LOCKDOWN = 2'd2,
        LOCKOUT  = 2'd3
    } reglk_state_e;

    // Control words sit directly above the data registers.
    localparam int LOCK_IDX_OFS   = 0;
    localparam int STATUS_IDX_OFS = 1;

    // Widest bus the merge helper supports; callers zero-extend and truncate.
    localparam int MERGE_MAX_W  = 256;
    localparam int MERGE_BE_W   = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] be_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_BE_W-1:0]  be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reglk_sat_cnt.sv
// Saturating up-counter; adds 0..3 per cycle and sticks at all-ones.
module reglk_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    // NOTE: the spare top bit catches the wrap, so saturation is a single compare.
    assign sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
    assign cnt_d = sum[W] ? '1 : sum[W-1:0];

    // NOTE: sequential state uses non-blocking assignment only; combinational logic uses blocking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reglk_bank.sv
// Register-lock bank: protected data words, W1S lock bits, sticky lockdown, violation counter.
// Optional keyed debug unlock with lockout is compiled in when REGLK_DBG_UNLOCK_EN is defined.
module reglk_bank
    import reglk_pkg::*;
#(
    parameter int                NUM_REGS       = 8,
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 8,
    parameter int                CNT_W          = 8,
    parameter int                LOCKOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] DBG_KEY        = DATA_W'(32'hC0DE_5EC1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          be_i,
    output logic                         rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         err_o,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]          lock_o,
    output logic                         lockdown_o,
    output logic [CNT_W-1:0]             viol_cnt_o,
    input  logic                         dbg_unlock_req_i,
    input  logic [DATA_W-1:0]            dbg_key_i
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LOCK_IDX   = IDX_W'(NUM_REGS + LOCK_IDX_OFS);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS + STATUS_IDX_OFS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d, lock_set, wr_lock_bits;
    logic                lockdown_q, lockdown_d, lockdown_set;
    reglk_state_e        state_q, state_d;

    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    widx;
    logic [NUM_REGS-1:0] hit_reg;
    logic                hit_lock, hit_status, mapped;
    logic [DATA_W-1:0]   status_word;
    logic                viol_bus;
    logic                dbg_clear, dbg_viol;
    logic [1:0]          viol_inc;
    logic [CNT_W-1:0]    viol_cnt;

    assign widx       = addr_i[ADDR_W-1:2];
    assign hit_lock   = (widx == LOCK_IDX);
    assign hit_status = (widx == STATUS_IDX);
    assign mapped     = (|hit_reg) | hit_lock | hit_status;

    always_comb begin
        hit_reg      = '0;
        wr_lock_bits = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_reg[i]      = (widx == IDX_W'(i));
            wr_lock_bits[i] = wdata_i[i] & be_i[i/8];
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[0]             = lockdown_q;
        status_word[CNT_W+7:8]     = viol_cnt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        regs_d       = regs_q;
        lock_set     = '0;
        lockdown_set = 1'b0;
        viol_bus     = 1'b0;
        err_d        = 1'b0;
        rdata_d      = '0;
        if (req_i) begin
            if (!mapped) begin
                err_d = 1'b1;
            end else if (we_i) begin
                if (lockdown_q) begin
                    // Lockdown turns every mapped write into a violation, even no-op ones.
                    err_d    = 1'b1;
                    viol_bus = 1'b1;
                end else if (hit_lock) begin
                    lock_set = wr_lock_bits;
                end else if (hit_status) begin
                    lockdown_set = wdata_i[0] & be_i[0];
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (hit_reg[i]) begin
                            if (lock_q[i]) begin
                                err_d    = 1'b1;
                                viol_bus = 1'b1;
                            end else begin
                                regs_d[i] = DATA_W'(be_merge(MERGE_MAX_W'(regs_q[i]),
                                                             MERGE_MAX_W'(wdata_i),
                                                             MERGE_BE_W'(be_i)));
                            end
                        end
                    end
                end
            end else begin
                if (hit_lock) begin
                    rdata_d = DATA_W'(lock_q);
                end else if (hit_status) begin
                    rdata_d = status_word;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (hit_reg[i]) rdata_d = regs_q[i];
                    end
                end
            end
        end
    end

    assign lockdown_d = lockdown_q | lockdown_set;
    // A bus set in the same cycle as a debug clear survives the clear.
    assign lock_d     = dbg_clear ? lock_set : (lock_q | lock_set);

`ifdef REGLK_DBG_UNLOCK_EN
    localparam int LO_W = $clog2(LOCKOUT_CYCLES + 1);

    logic            dbg_pend_q, dbg_match_q, dbg_accept, dbg_live, dbg_ready;
    logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
    logic            unused_ok;

    assign dbg_ready  = (state_q == OPEN) || (state_q == LOCKED);
    assign dbg_accept = dbg_unlock_req_i && dbg_ready && !dbg_pend_q;
    assign dbg_live   = dbg_pend_q && dbg_ready && !lockdown_d;
    assign dbg_clear  = dbg_live && dbg_match_q;
    assign dbg_viol   = dbg_live && !dbg_match_q;
    assign unused_ok  = ^addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbg_pend_q  <= 1'b0;
            dbg_match_q <= 1'b0;
            lo_cnt_q    <= '0;
        end else begin
            dbg_pend_q  <= dbg_accept;
            dbg_match_q <= (dbg_key_i == DBG_KEY);
            lo_cnt_q    <= lo_cnt_d;
        end
    end
`else
    logic unused_ok;

    assign dbg_clear = 1'b0;
    assign dbg_viol  = 1'b0;
    assign unused_ok = ^{addr_i[1:0], dbg_unlock_req_i, dbg_key_i, DBG_KEY}
                       ^ (LOCKOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d  = state_q;
`ifdef REGLK_DBG_UNLOCK_EN
        lo_cnt_d = lo_cnt_q;
`endif
        case (state_q)
            OPEN, LOCKED: begin
                if (lockdown_d) begin
                    state_d = LOCKDOWN;
                end else if (dbg_viol) begin
                    state_d = LOCKOUT;
`ifdef REGLK_DBG_UNLOCK_EN
                    lo_cnt_d = LO_W'(LOCKOUT_CYCLES);
`endif
                end else begin
                    state_d = (|lock_d) ? LOCKED : OPEN;
                end
            end
            LOCKDOWN: state_d = LOCKDOWN;
            default: begin
`ifdef REGLK_DBG_UNLOCK_EN
                if (lockdown_d)             state_d = LOCKDOWN;
                else if (lo_cnt_q == '0)    state_d = (|lock_d) ? LOCKED : OPEN;
                else                        lo_cnt_d = lo_cnt_q - 1'b1;
`else
                state_d = lockdown_d ? LOCKDOWN : ((|lock_d) ? LOCKED : OPEN);
`endif
            end
        endcase
    end

    // NOTE: the data words are discrete flops rather than a RAM, so they reset with the rest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            lock_q     <= '0;
            lockdown_q <= 1'b0;
            state_q    <= OPEN;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            lock_q     <= lock_d;
            lockdown_q <= lockdown_d;
            state_q    <= state_d;
            rvalid_q   <= req_i;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign viol_inc = {1'b0, viol_bus} + {1'b0, dbg_viol};

    reglk_sat_cnt #(.W(CNT_W)) u_viol_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (viol_inc),
        .cnt_o  (viol_cnt)
    );

    always_comb begin
        reg_q_o = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q_o[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign lock_o     = lock_q | {NUM_REGS{lockdown_q}};
    assign lockdown_o = lockdown_q;
    assign viol_cnt_o = viol_cnt;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_reglk_bank.sv
// Directed self-checking bench for reglk_bank with default parameters.
module tb_reglk_bank;

    localparam logic [7:0]  LOCK_A   = 8'h20;
    localparam logic [7:0]  STATUS_A = 8'h24;
    localparam logic [31:0] KEY_OK   = 32'hC0DE_5EC1;
    localparam logic [31:0] KEY_BAD  = 32'h1234_5678;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [7:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   be = '0;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         err;
    logic [255:0] reg_q;
    logic [7:0]   lock;
    logic         lockdown;
    logic [7:0]   viol_cnt;
    logic         dbg_req = 1'b0;
    logic [31:0]  dbg_key = '0;

    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reglk_bank dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .we_i             (we),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .be_i             (be),
        .rvalid_o         (rvalid),
        .rdata_o          (rdata),
        .err_o            (err),
        .reg_q_o          (reg_q),
        .lock_o           (lock),
        .lockdown_o       (lockdown),
        .viol_cnt_o       (viol_cnt),
        .dbg_unlock_req_i (dbg_req),
        .dbg_key_i        (dbg_key)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        rsp_valid = rvalid; rsp_data = rdata; rsp_err = err;
    endtask

    task automatic dbg_pulse(input logic [31:0] k);
        @(negedge clk);
        dbg_req = 1'b1; dbg_key = k;
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({rvalid, err, rdata} !== 34'h0) $display("FAIL reset_rsp got=%h exp=0", {rvalid, err, rdata}); else passed++;
        total++; if (reg_q !== '0) $display("FAIL reset_regs got=%h exp=0", reg_q); else passed++;
        total++; if ({lock, lockdown, viol_cnt} !== 17'h0) $display("FAIL reset_lock got=%h exp=0", {lock, lockdown, viol_cnt}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rw();
        do_req(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF);
        total++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL wr_reg2_rsp got=%b exp=10", {rsp_valid, rsp_err}); else passed++;
        do_req(1'b0, 8'h08, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0) $display("FAIL rd_reg2 got=%h/%b exp=deadbeef/0", rsp_data, rsp_err); else passed++;
        total++; if (reg_q[64 +: 32] !== 32'hDEAD_BEEF) $display("FAIL reg_q2 got=%h exp=deadbeef", reg_q[64 +: 32]); else passed++;
    endtask

    task automatic test_be_merge();
        do_req(1'b1, 8'h00, 32'h1122_3344, 4'hF);
        do_req(1'b1, 8'h00, 32'h0000_AB00, 4'b0010);
        do_req(1'b0, 8'h00, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'h1122_AB44) $display("FAIL be_merge got=%h exp=1122ab44", rsp_data); else passed++;
    endtask

    task automatic test_lock();
        do_req(1'b1, LOCK_A, 32'h4, 4'hF);
        total++; if (rsp_err !== 1'b0 || lock !== 8'h04) $display("FAIL lock_set got=%b/%h exp=0/04", rsp_err, lock); else passed++;
        do_req(1'b1, 8'h08, 32'h0, 4'hF);
        total++; if (rsp_err !== 1'b1) $display("FAIL locked_wr_err got=%b exp=1", rsp_err); else passed++;
        total++; if (reg_q[64 +: 32] !== 32'hDEAD_BEEF || viol_cnt !== 8'd1) $display("FAIL locked_wr_state got=%h/%0d exp=deadbeef/1", reg_q[64 +: 32], viol_cnt); else passed++;
        do_req(1'b1, LOCK_A, 32'h0, 4'hF);
        total++; if (rsp_err !== 1'b0 || lock !== 8'h04) $display("FAIL lock_clear_noop got=%b/%h exp=0/04", rsp_err, lock); else passed++;
        do_req(1'b0, LOCK_A, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'h4) $display("FAIL rd_lock got=%h exp=4", rsp_data); else passed++;
    endtask

    task automatic test_unmapped();
        do_req(1'b0, 8'h30, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'h0 || rsp_err !== 1'b1) $display("FAIL unmapped_rd got=%h/%b exp=0/1", rsp_data, rsp_err); else passed++;
        do_req(1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF);
        total++; if (rsp_err !== 1'b1 || viol_cnt !== 8'd1) $display("FAIL unmapped_wr got=%b/%0d exp=1/1", rsp_err, viol_cnt); else passed++;
        do_req(1'b0, STATUS_A, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'h0000_0100 || rsp_err !== 1'b0) $display("FAIL rd_status got=%h/%b exp=00000100/0", rsp_data, rsp_err); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h04; wdata = 32'hA5A5_0F0F; be = 4'hF;
        @(posedge clk);
        #1;
        total++; if ({rvalid, err} !== 2'b10) $display("FAIL b2b_wr got=%b exp=10", {rvalid, err}); else passed++;
        we = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        total++; if (rvalid !== 1'b1 || rdata !== 32'hA5A5_0F0F) $display("FAIL b2b_rd got=%b/%h exp=1/a5a50f0f", rvalid, rdata); else passed++;
        tick();
        total++; if (rvalid !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", rvalid); else passed++;
    endtask

    task automatic test_lockdown();
        apply_reset();
        do_req(1'b1, 8'h00, 32'h0000_0055, 4'hF);
        do_req(1'b1, STATUS_A, 32'h1, 4'hF);
        total++; if (rsp_err !== 1'b0 || lockdown !== 1'b1 || lock !== 8'hFF) $display("FAIL lockdown_set got=%b/%b/%h exp=0/1/ff", rsp_err, lockdown, lock); else passed++;
        do_req(1'b1, 8'h00, 32'h0, 4'hF);
        total++; if (rsp_err !== 1'b1) $display("FAIL ld_wr_reg got=%b exp=1", rsp_err); else passed++;
        do_req(1'b1, LOCK_A, 32'h0, 4'hF);
        total++; if (rsp_err !== 1'b1) $display("FAIL ld_wr_lock got=%b exp=1", rsp_err); else passed++;
        do_req(1'b1, STATUS_A, 32'h1, 4'hF);
        total++; if (rsp_err !== 1'b1) $display("FAIL ld_wr_status got=%b exp=1", rsp_err); else passed++;
        total++; if (viol_cnt !== 8'd3 || reg_q[31:0] !== 32'h55) $display("FAIL ld_state got=%0d/%h exp=3/55", viol_cnt, reg_q[31:0]); else passed++;
        do_req(1'b0, STATUS_A, 32'h0, 4'hF);
        total++; if (rsp_data !== 32'h0000_0301) $display("FAIL ld_rd_status got=%h exp=00000301", rsp_data); else passed++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({reg_q[31:0], lock, lockdown, viol_cnt} !== 49'h0) $display("FAIL async_reset got=%h exp=0", {reg_q[31:0], lock, lockdown, viol_cnt}); else passed++;
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        do_req(1'b1, LOCK_A, 32'h1, 4'hF);
        for (int i = 0; i < 255; i++) do_req(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF);
        total++; if (viol_cnt !== 8'd255) $display("FAIL sat_reach got=%0d exp=255", viol_cnt); else passed++;
        for (int i = 0; i < 45; i++) do_req(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF);
        total++; if (viol_cnt !== 8'd255 || rsp_err !== 1'b1) $display("FAIL sat_hold got=%0d/%b exp=255/1", viol_cnt, rsp_err); else passed++;
    endtask

`ifdef REGLK_DBG_UNLOCK_EN
    task automatic test_dbg_unlock();
        apply_reset();
        do_req(1'b1, LOCK_A, 32'h8, 4'hF);
        dbg_pulse(KEY_BAD);
        tick();
        total++; if (viol_cnt !== 8'd1 || lock !== 8'h08) $display("FAIL dbg_bad_key got=%0d/%h exp=1/08", viol_cnt, lock); else passed++;
        repeat (5) tick();
        dbg_pulse(KEY_OK);
        repeat (3) tick();
        total++; if (lock !== 8'h08) $display("FAIL dbg_lockout_ignore got=%h exp=08", lock); else passed++;
        repeat (70) tick();
        dbg_pulse(KEY_OK);
        total++; if (lock !== 8'h08) $display("FAIL dbg_clear_early got=%h exp=08", lock); else passed++;
        tick();
        total++; if (lock !== 8'h00 || viol_cnt !== 8'd1) $display("FAIL dbg_clear got=%h/%0d exp=00/1", lock, viol_cnt); else passed++;
        do_req(1'b1, LOCK_A, 32'h2, 4'hF);
        dbg_pulse(KEY_OK);
        do_req(1'b1, LOCK_A, 32'h10, 4'hF);
        total++; if (lock !== 8'h10 || rsp_err !== 1'b0) $display("FAIL dbg_set_wins got=%h/%b exp=10/0", lock, rsp_err); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_rw();
        test_be_merge();
        test_lock();
        test_unmapped();
        test_back_to_back();
        test_lockdown();
        test_saturation();
`ifdef REGLK_DBG_UNLOCK_EN
        test_dbg_unlock();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
